// File: rtl/decade_decoder_if.sv
// Bundle between a decade-counter front end and the decade decoder:
// sample strobe, one-hot code, carry and clear in; decoded digit, wrap count and status out.
interface decade_decoder_if;
    logic       sample_en;
    logic [9:0] number_bit;
    logic       carry_in;
    logic       clear_err;
    logic [3:0] digit;
    logic       digit_valid;
    logic [6:0] wrap_count;
    logic       wrap_pulse;
    logic       onehot_err;
    logic       seq_err;
    logic       carry_err;
    logic [1:0] state_o;

    modport master (
        output sample_en, number_bit, carry_in, clear_err,
        input  digit, digit_valid, wrap_count, wrap_pulse,
        input  onehot_err, seq_err, carry_err, state_o
    );

    modport slave (
        input  sample_en, number_bit, carry_in, clear_err,
        output digit, digit_valid, wrap_count, wrap_pulse,
        output onehot_err, seq_err, carry_err, state_o
    );
endinterface

// File: rtl/decade_decoder.sv
// Tracks a one-hot decade counter: locks on digit 0, follows hold/+1/wrap/restart,
// counts 9->0 wraps and raises sticky one-hot, sequence and carry errors.
module decade_decoder #(
    parameter int CHECK_CARRY = 1,
    parameter int WRAP_MOD    = 100
) (
    input  logic            clock,
    input  logic            reset,
    decade_decoder_if.slave bus
);
    typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

    localparam logic [6:0] WRAP_LAST = 7'(WRAP_MOD - 1);

    state_t     state_p1, state_p0;
    logic [3:0] digit_p1, digit_p0;
    logic [6:0] wrap_p1, wrap_p0;
    logic       pulse_p1, pulse_p0;
    logic       onehot_p1, onehot_p0;
    logic       seq_p1, seq_p0;
    logic       carry_p1, carry_p0;
    logic       hist_vld_p1, hist_vld_p0;
    logic       valid_p1;
    logic       legal;
    logic [3:0] idx;

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] encode(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 10; k++)
            if (v[k]) r = 4'(k);
        return r;
    endfunction

    function automatic logic [6:0] wrap_inc(input logic [6:0] c);
        return (c >= WRAP_LAST) ? 7'd0 : c + 7'd1;
    endfunction

    assign legal = is_onehot(bus.number_bit);
    assign idx   = encode(bus.number_bit);

    always_comb begin
        state_p0    = state_p1;
        digit_p0    = digit_p1;
        wrap_p0     = wrap_p1;
        pulse_p0    = 1'b0;
        onehot_p0   = onehot_p1;
        seq_p0      = seq_p1;
        carry_p0    = carry_p1;
        hist_vld_p0 = 1'b0;
        if (bus.clear_err) begin
            state_p0  = SYNC;
            onehot_p0 = 1'b0;
            seq_p0    = 1'b0;
            carry_p0  = 1'b0;
        end else if (bus.sample_en) begin
            hist_vld_p0 = (state_p1 == TRACK);
            // carry_in lags the code by one cycle, so it describes the digit we now hold
            if (CHECK_CARRY != 0 && hist_vld_p1 && (bus.carry_in != (digit_p1 <= 4'd4)))
                carry_p0 = 1'b1;
            case (state_p1)
                SYNC: begin
                    if (legal && idx == 4'd0) begin
                        state_p0 = TRACK;
                        digit_p0 = 4'd0;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        onehot_p0 = 1'b1;
                        state_p0  = FAULT;
                    end else if (idx == digit_p1) begin
                        digit_p0 = digit_p1;
                    end else if (digit_p1 <= 4'd8 && idx == digit_p1 + 4'd1) begin
                        digit_p0 = idx;
                    end else if (idx == 4'd0 && digit_p1 == 4'd9) begin
                        digit_p0 = 4'd0;
                        wrap_p0  = wrap_inc(wrap_p1);
                        pulse_p0 = 1'b1;
                    end else if (idx == 4'd0) begin
                        digit_p0 = 4'd0;
                    end else begin
                        seq_p0   = 1'b1;
                        state_p0 = FAULT;
                    end
                end
                default: ;
            endcase
        end
    end

    // registered output stage
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p1    <= SYNC;
            digit_p1    <= 4'd0;
            wrap_p1     <= 7'd0;
            pulse_p1    <= 1'b0;
            onehot_p1   <= 1'b0;
            seq_p1      <= 1'b0;
            carry_p1    <= 1'b0;
            hist_vld_p1 <= 1'b0;
            valid_p1    <= 1'b0;
        end else begin
            state_p1    <= state_p0;
            digit_p1    <= digit_p0;
            wrap_p1     <= wrap_p0;
            pulse_p1    <= pulse_p0;
            onehot_p1   <= onehot_p0;
            seq_p1      <= seq_p0;
            carry_p1    <= carry_p0;
            hist_vld_p1 <= hist_vld_p0;
            valid_p1    <= (state_p0 == TRACK);
        end
    end

    assign bus.digit       = digit_p1;
    assign bus.digit_valid = valid_p1;
    assign bus.wrap_count  = wrap_p1;
    assign bus.wrap_pulse  = pulse_p1;
    assign bus.onehot_err  = onehot_p1;
    assign bus.seq_err     = seq_p1;
    assign bus.carry_err   = carry_p1;
    assign bus.state_o     = state_p1;
endmodule

// File: tb/tb_decade_decoder.sv
// Self-checking bench for decade_decoder: default, no-carry-check and WRAP_MOD=4 instances
// share one stimulus stream; expected results are queued on drive and checked one cycle later.
module tb_decade_decoder;
    localparam logic [1:0] S = 2'd0, T = 2'd1, F = 2'd2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decade_decoder_if bus();
    decade_decoder_if bus_nc();
    decade_decoder_if bus_w4();

    decade_decoder dut (.clock(clock), .reset(reset), .bus(bus));
    decade_decoder #(.CHECK_CARRY(0)) dut_nc (.clock(clock), .reset(reset), .bus(bus_nc));
    decade_decoder #(.WRAP_MOD(4)) dut_w4 (.clock(clock), .reset(reset), .bus(bus_w4));

    typedef struct {
        logic       rst, se, clr, cin;
        logic [9:0] nb;
        logic [1:0] st;
        logic [3:0] dg;
        logic [6:0] wc;
        logic       wp, oe, sq, ce;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [9:0] oh(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    function automatic logic cy(input int d);
        return d <= 4;
    endfunction

    function automatic vec_t v(input logic rst, se, clr, input logic [9:0] nb, input logic cin,
                               input logic [1:0] st, input int dg, wc,
                               input logic wp, oe, sq, ce);
        vec_t r;
        r.rst = rst; r.se = se; r.clr = clr; r.nb = nb; r.cin = cin;
        r.st = st; r.dg = 4'(dg); r.wc = 7'(wc);
        r.wp = wp; r.oe = oe; r.sq = sq; r.ce = ce;
        return r;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic check_head();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got 0 entries, want 1");
            return;
        end
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.state_o, bus.digit, bus.digit_valid, bus.wrap_count, bus.wrap_pulse,
             bus.onehot_err, bus.seq_err, bus.carry_err} !==
            {e.st, e.dg, (e.st == T), e.wc, e.wp, e.oe, e.sq, e.ce}) begin
            n_fail++;
            $display("FAIL vec%0d: got st=%0d dg=%0d dv=%0b wc=%0d wp=%0b oe=%0b sq=%0b ce=%0b, want st=%0d dg=%0d dv=%0b wc=%0d wp=%0b oe=%0b sq=%0b ce=%0b",
                     n_tests, bus.state_o, bus.digit, bus.digit_valid, bus.wrap_count, bus.wrap_pulse,
                     bus.onehot_err, bus.seq_err, bus.carry_err,
                     e.st, e.dg, (e.st == T), e.wc, e.wp, e.oe, e.sq, e.ce);
        end
        chk("nc_carry_err", 7'(bus_nc.carry_err), 7'd0);
    endtask

    task automatic drive(input vec_t x);
        reset = x.rst;
        bus.sample_en = x.se;    bus.number_bit = x.nb;    bus.carry_in = x.cin;    bus.clear_err = x.clr;
        bus_nc.sample_en = x.se; bus_nc.number_bit = x.nb; bus_nc.carry_in = x.cin; bus_nc.clear_err = x.clr;
        bus_w4.sample_en = x.se; bus_w4.number_bit = x.nb; bus_w4.carry_in = x.cin; bus_w4.clear_err = x.clr;
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        check_head();
    endtask

    initial begin
        // continuous 0..9,0,1 with a consistent carry
        tbl.push_back(v(1, 0, 0, 10'd0, 0, S, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(0), 0, T, 0, 0, 0, 0, 0, 0));
        for (int d = 1; d <= 9; d++)
            tbl.push_back(v(0, 1, 0, oh(d), cy(d - 1), T, d, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(0), cy(9), T, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(1), cy(0), T, 1, 1, 0, 0, 0, 0));
        // inhibit hold and sample_en gaps
        tbl.push_back(v(0, 1, 0, oh(2), cy(1), T, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(3), cy(2), T, 3, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 1, 0, oh(3), cy(3), T, 3, 1, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(v(0, 0, 0, 10'd0, 0, T, 3, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(4), cy(3), T, 4, 1, 0, 0, 0, 0));
        // restart, one-hot fault, clear
        tbl.push_back(v(0, 1, 0, oh(0), cy(4), T, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(1), cy(0), T, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(2), cy(1), T, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 10'b0000010100, 1, F, 2, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 10'd0, 0, S, 2, 1, 0, 0, 0, 0));
        // sequence skip fault, sampling ignored in FAULT
        tbl.push_back(v(0, 1, 0, oh(0), 0, T, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(1), cy(0), T, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(2), cy(1), T, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(5), cy(2), F, 2, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, oh(3), 1, F, 2, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 10'd0, 0, S, 2, 1, 0, 0, 0, 0));
        // carry mismatch at digit 6 stays in TRACK
        tbl.push_back(v(0, 1, 0, oh(0), 0, T, 0, 1, 0, 0, 0, 0));
        for (int d = 1; d <= 6; d++)
            tbl.push_back(v(0, 1, 0, oh(d), cy(d - 1), T, d, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, oh(7), 1, T, 7, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, oh(8), cy(7), T, 8, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 10'd0, 0, S, 8, 1, 0, 0, 0, 0));

        foreach (tbl[i]) drive(tbl[i]);

        // five decades against WRAP_MOD=100 and WRAP_MOD=4, then a 7->0 restart
        drive(v(1, 0, 0, 10'd0, 0, S, 0, 0, 0, 0, 0, 0));
        drive(v(0, 1, 0, oh(0), 0, T, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            for (int d = 1; d <= 9; d++)
                drive(v(0, 1, 0, oh(d), cy(d - 1), T, d, k - 1, 0, 0, 0, 0));
            drive(v(0, 1, 0, oh(0), cy(9), T, 0, k, 1, 0, 0, 0));
            chk($sformatf("w4_wrap%0d", k), bus_w4.wrap_count, 7'(k % 4));
            chk("w4_pulse", 7'(bus_w4.wrap_pulse), 7'd1);
        end
        for (int d = 1; d <= 7; d++)
            drive(v(0, 1, 0, oh(d), cy(d - 1), T, d, 5, 0, 0, 0, 0));
        drive(v(0, 1, 0, oh(0), cy(7), T, 0, 5, 0, 0, 0, 0));
        chk("w4_restart", bus_w4.wrap_count, 7'd1);
        chk("w4_restart_pulse", 7'(bus_w4.wrap_pulse), 7'd0);

        // priority: reset over clear, clear over a legal digit-0 sample, reset discards digit
        drive(v(0, 1, 0, 10'd0, 1, F, 0, 5, 0, 1, 0, 0));
        drive(v(1, 1, 1, oh(0), 0, S, 0, 0, 0, 0, 0, 0));
        chk("w4_after_reset", bus_w4.wrap_count, 7'd0);
        drive(v(0, 1, 0, oh(0), 0, T, 0, 0, 0, 0, 0, 0));
        drive(v(0, 1, 0, oh(3), 1, F, 0, 0, 0, 0, 1, 0));
        drive(v(0, 1, 1, oh(0), 0, S, 0, 0, 0, 0, 0, 0));
        drive(v(0, 1, 0, oh(0), 0, T, 0, 0, 0, 0, 0, 0));
        drive(v(0, 1, 0, oh(1), 1, T, 1, 0, 0, 0, 0, 0));
        drive(v(1, 1, 0, oh(2), 1, S, 0, 0, 0, 0, 0, 0));
        drive(v(0, 1, 0, oh(1), 1, S, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decade_decoder.md
DECADE_DECODER -- requirements
Module: decade_decoder

Interface
REQ-001 Parameter CHECK_CARRY, default 1: 1 enables carry consistency checking; 0 disables it and holds carry_err at 0.
REQ-002 Parameter WRAP_MOD, default 100: modulus of wrap_count; legal range 2..128.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port sample_en, input, 1: when high, number_bit and carry_in are sampled this cycle.
REQ-006 Port number_bit, input, 10: one-hot decade code from a decade counter; bit k set means digit k.
REQ-007 Port carry_in, input, 1: counter carry, registered one cycle behind number_bit; high while the previous digit was 0..4.
REQ-008 Port clear_err, input, 1: single-cycle pulse that clears sticky errors and returns to SYNC.
REQ-009 Port digit, output, 4: binary value of the last accepted digit, 0..9.
REQ-010 Port digit_valid, output, 1: high while in TRACK.
REQ-011 Port wrap_count, output, 7: number of 9->0 wraps, modulo WRAP_MOD.
REQ-012 Port wrap_pulse, output, 1: one-cycle pulse per accepted 9->0 wrap.
REQ-013 Port onehot_err, seq_err, carry_err, output, 1 each: sticky error flags.
REQ-014 Port state_o, output, 2: current state; SYNC=0, TRACK=1, FAULT=2.

Function
REQ-015 All outputs are registered and reflect a sample taken in cycle n at cycle n+1 (latency 1).
REQ-016 A sample is legal when exactly one bit of number_bit is set; digit index = position of the set bit.
REQ-017 SYNC: a legal sample of 10'b0000000001 moves to TRACK with digit=0; all other samples are ignored and raise no error.
REQ-018 TRACK, legal sample equal to digit (counter inhibited): no state or output change.
REQ-019 TRACK, legal sample equal to digit+1 (digit<=8): digit updates to the new value.
REQ-020 TRACK, digit=9 and sample=0: digit=0, wrap_count increments modulo WRAP_MOD, wrap_pulse=1 for one cycle.
REQ-021 TRACK, sample=0 while digit is not 9 (counter reset): digit=0 as a restart; wrap_count unchanged; no wrap_pulse.
REQ-022 TRACK, illegal sample: onehot_err set, go to FAULT.
REQ-023 TRACK, legal sample that is not hold, +1, wrap or restart: seq_err set, go to FAULT.
REQ-024 In FAULT, digit and wrap_count hold their values; digit_valid=0; sampling has no effect.
REQ-025 Carry check (CHECK_CARRY=1): performed only when sample_en was high in both this and the previous cycle and state was TRACK in the previous cycle; requires carry_in == (digit held at the previous sample <= 4).
REQ-026 A carry mismatch sets carry_err only; the state does not change.
REQ-027 clear_err (any state): clears onehot_err, seq_err and carry_err and moves to SYNC; wrap_count is retained.
REQ-028 If clear_err and sample_en are high in the same cycle, clear_err wins and the sample is discarded.
REQ-029 When sample_en is low: no state change, no error checks, wrap_pulse=0.

Reset
REQ-030 When reset is high at a clock edge: state=SYNC, digit=0, digit_valid=0, wrap_count=0, wrap_pulse=0, all error flags 0, carry-check history invalidated; this takes precedence over clear_err and sampling.
REQ-031 A reset during TRACK or FAULT discards the current digit; re-acquisition requires a new digit-0 sample.

Verification
REQ-032 Sequence test: after reset, feed continuous samples 0,1,...,9,0,1 with matching carry -> TRACK from cycle 2; wrap_pulse once; wrap_count=1; all error flags 0.
REQ-033 Inhibit and gaps: hold sample 3 for 5 cycles, drop sample_en for 2 cycles, then sample 4 -> digit stays 3, then becomes 4; no errors.
REQ-034 Fault detection: in TRACK at digit 2, sample 10'b0000010100 -> onehot_err=1 and FAULT; after clear_err -> all flags 0 and SYNC. Separately, a 2->5 skip -> seq_err=1 and FAULT.
REQ-035 Carry check: in TRACK at digit 6, carry_in=1 on the next sample -> carry_err=1 while staying in TRACK; with CHECK_CARRY=0 the same stimulus -> carry_err=0.
REQ-036 Wrap modulus: WRAP_MOD=4, 5 full decades -> wrap_count sequence 1,2,3,0,1. Restart: 7->0 leaves wrap_count unchanged.
REQ-037 Priority: reset and clear_err together in FAULT -> reset values; clear_err with a legal sample 0 in FAULT -> state SYNC (not TRACK).
